program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_pkg.sv | 10 +
 rtl/program_sequencer_return_stack.sv | 50 +++++
 rtl/program_sequencer.sv | 105 ++++++++++
 tb/tb_program_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: the per-cycle action selection.
package sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ,
    JUMP,
    RET
  } action_e;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// Circular return-address stack; a push when full silently replaces the oldest entry.
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_value,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    push_ptr;
  logic             do_pop;

  assign push_ptr = top_ptr + PTR_ONE;
  assign do_pop   = pop && (count != '0);
  assign top      = mem[top_ptr];

  // Pointer wraps, so the oldest slot is the one overwritten when count is saturated.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= push_ptr;
      if (count != CNT_DEPTH)
        count <= count + CNT_ONE;
    end else if (do_pop) begin
      top_ptr <= top_ptr - PTR_ONE;
      count   <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[push_ptr] <= push_value;
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with absolute/relative jumps, call/return via a small return stack.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STACK_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable_count,
  input  logic                          jump_valid,
  input  logic                          jump_relative,
  input  logic [WIDTH-1:0]              jump_value,
  input  logic                          call,
  input  logic                          ret,
  output logic [WIDTH-1:0]              out,
  output logic [$clog2(STACK_DEPTH):0]  stack_count,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [CW-1:0]    CNT_DEPTH = CW'(STACK_DEPTH);

  action_e          action;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_out;
  logic [WIDTH-1:0] stack_top;
  logic             push;
  logic             pop;
  logic             overflow_next;
  logic             underflow_next;

  assign seq_addr    = out + STEP_W;
  assign target      = jump_relative ? (out + jump_value) : jump_value;
  assign stack_full  = (stack_count == CNT_DEPTH);
  assign stack_empty = (stack_count == '0);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .push_value (seq_addr),
    .top        (stack_top),
    .count      (stack_count)
  );

  // Ret outranks jump, so a call riding along with ret never pushes.
  always_comb begin
    action         = SEQ;
    next_out       = out;
    push           = 1'b0;
    pop            = 1'b0;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (ret)
      action = RET;
    else if (jump_valid)
      action = JUMP;
    if (enable_count) begin
      case (action)
        RET: begin
          if (stack_empty) begin
            next_out       = seq_addr;
            underflow_next = 1'b1;
          end else begin
            next_out = stack_top;
            pop      = 1'b1;
          end
        end
        JUMP: begin
          next_out = target;
          if (call) begin
            push          = 1'b1;
            overflow_next = stack_full;
          end
        end
        default: next_out = seq_addr;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out       <= RESET_VECTOR;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out       <= next_out;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed and random checks of program_sequencer against a queue-based reference model.
module tb_program_sequencer;

  logic        clock;
  logic        reset_n;
  logic        enable_count;
  logic        jump_valid;
  logic        jump_relative;
  logic [31:0] jump_value;
  logic        call;
  logic        ret;
  logic [31:0] out;
  logic [2:0]  stack_count;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stack [$];
  logic        m_of;
  logic        m_uf;

  program_sequencer #(
    .WIDTH        (32),
    .STEP         (4),
    .RESET_VECTOR (32'h0),
    .STACK_DEPTH  (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable_count  (enable_count),
    .jump_valid    (jump_valid),
    .jump_relative (jump_relative),
    .jump_value    (jump_value),
    .call          (call),
    .ret           (ret),
    .out           (out),
    .stack_count   (stack_count),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [31:0] cnt;
    cnt = m_stack.size();
    check_value({tag, ".out"}, out, m_pc);
    check_value({tag, ".count"}, {29'd0, stack_count}, cnt);
    check_value({tag, ".full"}, {31'd0, stack_full}, {31'd0, cnt == 4});
    check_value({tag, ".empty"}, {31'd0, stack_empty}, {31'd0, cnt == 0});
    check_value({tag, ".overflow"}, {31'd0, overflow}, {31'd0, m_of});
    check_value({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_uf});
  endtask

  function automatic void model_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
  endfunction

  // Reference behaviour: ret beats jump beats sequential; stack keeps the newest 4 addresses.
  function automatic void model_step(input bit en, input bit jv, input bit rel,
                                     input logic [31:0] val, input bit cl, input bit rt);
    logic [31:0] tgt;
    m_of = 1'b0;
    m_uf = 1'b0;
    if (!en) return;
    if (rt) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else begin
        m_pc = m_pc + 32'd4;
        m_uf = 1'b1;
      end
    end else if (jv) begin
      tgt = rel ? m_pc + val : val;
      if (cl) begin
        m_stack.push_back(m_pc + 32'd4);
        if (m_stack.size() > 4) begin
          void'(m_stack.pop_front());
          m_of = 1'b1;
        end
      end
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic apply_stimulus(input string tag, input bit en, input bit jv, input bit rel,
                                input logic [31:0] val, input bit cl, input bit rt);
    enable_count  = en;
    jump_valid    = jv;
    jump_relative = rel;
    jump_value    = val;
    call          = cl;
    ret           = rt;
    model_step(en, jv, rel, val, cl, rt);
    @(posedge clock);
    #1;
    check_output(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    enable_count = 1'b0; jump_valid = 1'b0; jump_relative = 1'b0;
    jump_value = 32'h0; call = 1'b0; ret = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_output("reset");
    reset_n = 1'b1;

    apply_stimulus("seq1", 1, 0, 0, 32'h0, 0, 0);
    apply_stimulus("seq2", 1, 0, 0, 32'h0, 0, 0);
    apply_stimulus("seq3", 1, 0, 0, 32'h0, 0, 0);
    check_value("seq3.const", out, 32'd12);

    apply_stimulus("jmp100", 1, 1, 0, 32'h100, 0, 0);
    apply_stimulus("jmp2000", 1, 1, 0, 32'h2000, 0, 0);
    check_value("jmp2000.const", out, 32'h2000);
    apply_stimulus("jmprel", 1, 1, 1, 32'hFFFF_FFF0, 0, 0);
    check_value("jmprel.const", out, 32'h1FF0);

    apply_stimulus("to40", 1, 1, 0, 32'h40, 0, 0);
    apply_stimulus("call800", 1, 1, 0, 32'h800, 1, 0);
    check_value("call800.count", {29'd0, stack_count}, 32'd1);
    apply_stimulus("sub1", 1, 0, 0, 32'h0, 1, 0);
    apply_stimulus("sub2", 1, 0, 0, 32'h0, 0, 0);
    check_value("sub2.const", out, 32'h808);
    apply_stimulus("ret44", 1, 0, 0, 32'h0, 0, 1);
    check_value("ret44.const", out, 32'h44);

    apply_stimulus("to0", 1, 1, 0, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++)
      apply_stimulus($sformatf("nest%0d", i), 1, 1, 0, 32'(i * 16), 1, 0);
    check_value("nest5.overflow", {31'd0, overflow}, 32'd1);
    apply_stimulus("ret_a", 1, 0, 0, 32'h0, 0, 1);
    check_value("ret_a.const", out, 32'h44);
    apply_stimulus("ret_b", 1, 0, 0, 32'h0, 0, 1);
    apply_stimulus("ret_c", 1, 0, 0, 32'h0, 0, 1);
    apply_stimulus("ret_d", 1, 0, 0, 32'h0, 0, 1);
    check_value("ret_d.const", out, 32'h14);
    apply_stimulus("ret_e", 1, 0, 0, 32'h0, 0, 1);
    check_value("ret_e.underflow", {31'd0, underflow}, 32'd1);

    apply_stimulus("to300", 1, 1, 0, 32'h300, 0, 0);
    apply_stimulus("call400", 1, 1, 0, 32'h400, 1, 0);
    apply_stimulus("prio", 1, 1, 0, 32'h999, 1, 1);
    check_value("prio.const", out, 32'h304);
    apply_stimulus("call500", 1, 1, 0, 32'h500, 1, 0);
    for (int i = 0; i < 3; i++)
      apply_stimulus($sformatf("freeze%0d", i), 0, 1, 1, 32'h1234, 1, 1);
    check_value("freeze.const", out, 32'h500);

    apply_stimulus("toFFC", 1, 1, 0, 32'hFFFF_FFFC, 0, 0);
    apply_stimulus("wrap", 1, 0, 0, 32'h0, 0, 0);
    check_value("wrap.const", out, 32'h0);

    apply_stimulus("pre_rst", 1, 1, 0, 32'hABC0, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_output("async_rst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    apply_stimulus("post_rst", 1, 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      apply_stimulus($sformatf("rnd%0d", i),
                     $urandom_range(0, 9) != 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom(),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
